// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/sequencing engine.
package fetch_pkg;

  localparam int OPCODE_W   = 4;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/DECODE/EXEC engine that owns PC and IR.
// Optional fetch watchdog (fetch_err pulse + retry gap) enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [OPCODE_W-1:0] HALT_OP  = 4'hF,
  parameter int                  TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                ctl_incpc,
  input  logic                ctl_ldpc,
  input  logic [ADDR_W-1:0]   branch_addr,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  output logic                halted,
  output logic                fetch_err
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_FETCH  = FETCH;
  localparam logic [2:0] ST_DECODE = DECODE;
  localparam logic [2:0] ST_EXEC   = EXEC;
  localparam logic [2:0] ST_HALT   = HALT;

  logic [2:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic               run_reg;
  logic               req_active;
  logic               fetch_hit;

  // run_reg gives the synchronous release: IDLE lasts one full cycle after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      run_reg   <= 1'b1;
    end
  end

  assign fetch_hit = req_active & mem_ack;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run_reg) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_hit) begin
          ir_next    = mem_rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = (opcode_of(ir_reg) == HALT_OP) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        // Branch beats increment when control_unit asserts both.
        if (ctl_ldpc) begin
          pc_next    = branch_addr;
          state_next = ST_FETCH;
        end else if (ctl_incpc) begin
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             gap_reg, gap_next;

  // Counter is zero outside FETCH, so it restarts on every FETCH entry and after each gap.
  always_comb begin
    cnt_next = '0;
    gap_next = 1'b0;
    if (req_active && !mem_ack) begin
      if (cnt_reg == CNT_LAST) gap_next = 1'b1;
      else                     cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      gap_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      gap_reg <= gap_next;
    end
  end

  assign req_active = (state_reg == ST_FETCH) && !gap_reg;
  assign fetch_err  = gap_reg;
`else
  assign req_active = (state_reg == ST_FETCH);
  // No watchdog: constant 0 for any legal TIMEOUT.
  assign fetch_err  = (TIMEOUT < 0);
`endif

  assign mem_req     = req_active;
  assign mem_addr    = pc_reg;
  assign pc          = pc_reg;
  assign ir          = ir_reg;
  assign opcode      = opcode_of(ir_reg);
  assign instr_valid = (state_reg == ST_DECODE);
  assign halted      = (state_reg == ST_HALT);

endmodule
